// File: rtl/registrador_instrucao_pkg.sv
// rtl/registrador_instrucao_pkg.sv - shared widths and enums for the instruction register stage
package registrador_instrucao_pkg;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    // Instruction format carried on the tipo output
    typedef enum logic [1:0] {
        TIPO_R = 2'b00,
        TIPO_I = 2'b01,
        TIPO_J = 2'b10
    } tipo_e;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        VAZIO = 2'b00,
        UM    = 2'b01,
        DOIS  = 2'b10
    } estado_e;

    function automatic tipo_e tipo_de_opcode(input logic [5:0] op);
        if (op == 6'd0) begin
            return TIPO_R;
        end else if (op == 6'd2 || op == 6'd3) begin
            return TIPO_J;
        end else begin
            return TIPO_I;
        end
    endfunction

endpackage

// File: rtl/registrador_instrucao_decodifica_campos.sv
// rtl/registrador_instrucao_decodifica_campos.sv - combinational field and format decoder
//
// Splits an instruction word into its fields and classifies its format.
// Ports:
//   instr    : instruction word to decode
//   opcode   : instr[31:26]
//   rs/rt/rd : instr[25:21], instr[20:16], instr[15:11]
//   funct    : instr[5:0]
//   imediato : instr[IMM_W-1:0], fed unextended to the extensor stage
//   tipo     : R / I / J format derived from opcode
module decodifica_campos
    import registrador_instrucao_pkg::*;
#(
    parameter int DATA_W = registrador_instrucao_pkg::DATA_W,
    parameter int IMM_W  = registrador_instrucao_pkg::IMM_W
) (
    input  logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [IMM_W-1:0]  imediato,
    output tipo_e             tipo
);

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imediato = instr[IMM_W-1:0];
    assign tipo     = tipo_de_opcode(instr[31:26]);

endmodule

// File: rtl/registrador_instrucao.sv
// rtl/registrador_instrucao.sv - two-entry in-order instruction register with field decode
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : fetch-side handshake, instr and pc captured on accept
//   flush               : synchronous discard of every held entry
//   out_valid/out_ready : decode-side handshake on the head entry
//   opcode..imediato    : decoded fields of the head, zero when empty
//   pc_out, tipo        : head PC and format, zero when empty
//   contagem            : running count of delivered instructions
module registrador_instrucao
    import registrador_instrucao_pkg::*;
#(
    parameter int DATA_W = registrador_instrucao_pkg::DATA_W,
    parameter int IMM_W  = registrador_instrucao_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [IMM_W-1:0]  imediato,
    output logic [DATA_W-1:0] pc_out,
    output logic [1:0]        tipo,
    output logic [15:0]       contagem
);

    estado_e           estado;
    logic [DATA_W-1:0] head_instr;
    logic [DATA_W-1:0] head_pc;
    logic [DATA_W-1:0] tail_instr;
    logic [DATA_W-1:0] tail_pc;

    logic accept;
    logic deliver;

    logic [5:0]       d_opcode;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_rd;
    logic [5:0]       d_funct;
    logic [IMM_W-1:0] d_imediato;
    tipo_e            d_tipo;

    // Handshake flags come straight from the registered state
    assign in_ready  = (estado != DOIS);
    assign out_valid = (estado != VAZIO);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= VAZIO;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
            contagem   <= 16'd0;
        end else if (flush) begin
            // Flush wins over any same-edge handshake; nothing is counted
            estado <= VAZIO;
        end else begin
            if (deliver) begin
                contagem <= contagem + 16'd1;
            end
            case (estado)
                VAZIO: begin
                    if (accept) begin
                        head_instr <= instr;
                        head_pc    <= pc;
                        estado     <= UM;
                    end
                end
                UM: begin
                    if (accept && deliver) begin
                        // Head leaves as the newcomer takes its place
                        head_instr <= instr;
                        head_pc    <= pc;
                    end else if (accept) begin
                        tail_instr <= instr;
                        tail_pc    <= pc;
                        estado     <= DOIS;
                    end else if (deliver) begin
                        estado <= VAZIO;
                    end
                end
                DOIS: begin
                    if (deliver) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        estado     <= UM;
                    end
                end
                default: estado <= VAZIO;
            endcase
        end
    end

    decodifica_campos #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decodifica_campos (
        .instr    (head_instr),
        .opcode   (d_opcode),
        .rs       (d_rs),
        .rt       (d_rt),
        .rd       (d_rd),
        .funct    (d_funct),
        .imediato (d_imediato),
        .tipo     (d_tipo)
    );

    // A stale head stays in the registers after draining, so gate on occupancy
    assign opcode   = out_valid ? d_opcode   : '0;
    assign rs       = out_valid ? d_rs       : '0;
    assign rt       = out_valid ? d_rt       : '0;
    assign rd       = out_valid ? d_rd       : '0;
    assign funct    = out_valid ? d_funct    : '0;
    assign imediato = out_valid ? d_imediato : '0;
    assign pc_out   = out_valid ? head_pc    : '0;
    assign tipo     = out_valid ? d_tipo     : TIPO_R;

endmodule

// File: doc/registrador_instrucao.md
REGISTRADOR_INSTRUCAO -- requirements
Module: registrador_instrucao

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, instruction and PC width.
REQ-002 SHALL have parameter IMM_W, default 16, immediate field width; the immediate feeds the extensor stage directly.

Interface
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port instr  input  DATA_W  fetched instruction word.
REQ-008 SHALL have port pc  input  DATA_W  address of instr.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head.
REQ-012 SHALL have port opcode  output  6  head instr[31:26].
REQ-013 SHALL have port rs, rt, rd  output  5 each  head instr[25:21], [20:16], [15:11].
REQ-014 SHALL have port funct  output  6  head instr[5:0].
REQ-015 SHALL have port imediato  output  IMM_W  head instr[15:0], the extensor input.
REQ-016 SHALL have port pc_out  output  DATA_W  head PC.
REQ-017 SHALL have port tipo  output  2  format: 00=R, 01=I, 10=J.
REQ-018 SHALL have port contagem  output  16  count of instructions delivered downstream.

Function
REQ-019 SHALL be a 2-entry in-order skid buffer with FSM states VAZIO, UM, DOIS.
REQ-020 SHALL drive in_ready = (state != DOIS) and out_valid = (state != VAZIO), both decoded from registered state only.
REQ-021 SHALL accept on in_valid&&in_ready and deliver on out_valid&&out_ready, both at the rising clk edge.
REQ-022 SHALL present an entry accepted at edge N at the outputs after edge N when the buffer was VAZIO (latency 1).
REQ-023 SHALL transition VAZIO->UM on accept; UM->DOIS on accept without deliver; UM->VAZIO on deliver without accept; UM->UM on simultaneous accept and deliver with the new entry becoming head; DOIS->UM on deliver, tail becoming head.
REQ-024 SHALL hold head outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHALL decode tipo as 00 when opcode=0, 10 when opcode=2 or 3, else 01.
REQ-026 SHALL drive the field outputs from the head regardless of tipo; imediato is always instr[15:0].
REQ-027 SHALL, on flush=1 at an edge, go to VAZIO; flush has priority over a same-cycle accept and deliver, and neither is counted.
REQ-028 SHALL increment contagem by 1 per delivery, wrapping 16'hFFFF->0; flush does not clear it.
REQ-029 SHALL drive field outputs to zero whenever state=VAZIO.

Reset
REQ-030 SHALL, while reset=0, force state=VAZIO, contagem=0, all entry registers and data outputs to 0, out_valid=0, in_ready=1, independent of clk.
REQ-031 SHALL discard entries held when reset asserts mid-operation and resume accepting at the first edge after release.

Structure
REQ-032 SHALL take DATA_W, IMM_W, the tipo encoding enum and the estado enum (VAZIO, UM, DOIS) from the shared package.
REQ-033 SHALL use one sub-module, decodifica_campos, a combinational field and tipo decoder applied to the head entry.

Verification
REQ-034 SHALL cover: reset low, then instr=32'h2008FFFC, pc=0, one-cycle valid, out_ready=1 -> next cycle out_valid=1, opcode=8, rt=8, imediato=16'hFFFC, tipo=01, then contagem=1.
REQ-035 SHALL cover: out_ready=0, two accepts 32'h00851020 then 32'h08000010 -> in_ready=0 in DOIS; release -> head rd=2, funct=6'h20, tipo=00, then tipo=10, order preserved.
REQ-036 SHALL cover: state UM, simultaneous accept and deliver for 10 consecutive cycles -> out_valid held 1, contagem advances by 10, no drop or duplicate.
REQ-037 SHALL cover: state DOIS, flush=1 with in_valid=1 and out_ready=1 -> next cycle VAZIO, out_valid=0, contagem unchanged.
REQ-038 SHALL cover: contagem preloaded to 16'hFFFF by 65535 deliveries, one more delivery -> contagem=0.
REQ-039 SHALL cover: reset asserted mid-cycle in DOIS -> outputs zero immediately, in_ready=1 before the next clk edge.
